// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM encoding, PC step, buffer entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          OP_MSB           = 31;
  localparam int          OP_LSB           = 26;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  // One buffered fetch: the address it came from and the word returned.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Opcode field as the decoder sees it.
  function automatic logic [OP_MSB-OP_LSB:0] instr_op(input logic [INSTR_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, redirect input, decode output.
// Latency: n/a (wiring only).
// Backpressure: decode uses instr_valid/instr_ready; memory side is strobe-based.
interface if_fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_en;
  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_rvalid;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [31:0]        instr_pc;
  logic               instr_ready;

  // Fetch unit side.
  modport master (
    output imem_en, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, imem_rvalid, redirect_valid, redirect_pc, instr_ready
  );

  // Memory / branch unit / decoder side.
  modport slave (
    input  imem_en, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, imem_rvalid, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a flush that beats push and pop.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller reserves space so push never meets full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !full && !flush;
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents of free slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // Space is reserved when a request is issued, so a push can never land on a full buffer.
  push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-at-a-time word reads, buffers {pc, instr} for decode.
// Latency: memory latency + 1 cycle from imem_en to instr_valid; FETCH_PIPELINE_EN overlaps issue with response.
// Backpressure: stops issuing once buffered + in-flight fetches would exceed FIFO_DEPTH; redirects flush.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   req_pc;
  logic [31:0]   req_pc_nxt;
  logic [31:0]   redirect_target;
  logic          issue;
  logic          push;
  logic          pop;
  logic          flush;
  logic          has_room;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: req_pc, instr: bus.imem_rdata}),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
  assign has_room        = (count < CW'(FIFO_DEPTH));

  // A redirecting cycle must not hand decode a stale head, so valid is masked combinationally.
  assign bus.instr_valid = !empty && !bus.redirect_valid && !rst;
  assign bus.instr       = empty ? '0 : head.instr;
  assign bus.instr_pc    = empty ? '0 : head.pc;
  assign bus.imem_addr   = pc;
  assign bus.imem_en     = issue;
  assign pop             = bus.instr_valid && bus.instr_ready;

`ifdef FETCH_PIPELINE_EN
  // After this cycle's push and pop, is there still a slot to reserve for another request?
  logic room_after_push;
  assign room_after_push = (count < CW'(FIFO_DEPTH - 1)) || (pop && has_room);
`endif

  // State, PC and request-PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_ISSUE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_pc_nxt;
    end
  end

  // Next-state, request issue and buffer control; redirect outranks every other event.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    issue      = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    if (!rst) begin
      case (state)
        S_ISSUE: begin
          if (bus.redirect_valid) begin
            pc_nxt = redirect_target;
            flush  = 1'b1;
          end else if (has_room) begin
            issue      = 1'b1;
            req_pc_nxt = pc;
            pc_nxt     = pc + PC_INC;
            state_nxt  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            pc_nxt    = redirect_target;
            flush     = 1'b1;
            // The in-flight response is now stale: drop it here or wait it out.
            state_nxt = bus.imem_rvalid ? S_ISSUE : S_DISCARD;
          end else if (bus.imem_rvalid) begin
            push = 1'b1;
`ifdef FETCH_PIPELINE_EN
            if (room_after_push) begin
              issue      = 1'b1;
              req_pc_nxt = pc;
              pc_nxt     = pc + PC_INC;
              state_nxt  = S_WAIT;
            end else begin
              state_nxt = S_ISSUE;
            end
`else
            state_nxt = S_ISSUE;
`endif
          end
        end
        S_DISCARD: begin
          if (bus.redirect_valid) begin
            pc_nxt = redirect_target;
            flush  = 1'b1;
          end
          if (bus.imem_rvalid) state_nxt = S_ISSUE;
        end
        default: state_nxt = S_ISSUE;
      endcase
    end
  end

endmodule
